vc_sched_arbiter: RTL and testbench
===================================

# vc_sched_arbiter

Virtual-channel scheduler that sits between the four VC input FIFOs and the shared output link. Each cycle it reads the VC selected by the current priority-table slot (`sched_vc`, driven by the priority-table interface). If that VC has data, it pops it. If not, it falls back to round-robin among the other non-empty VCs. It pulses `sched_adv` to step the table, stalls on downstream back-pressure, and keeps saturating statistics counters.

## Interface
- `DATA_W`, 8, width of each VC FIFO data word and of `data_out`
- `CNT_W`, 8, width of the saturating statistics counters
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `enb` in 1 — block enable; low forces IDLE
- `sched_vc` in 2 — VC selected by the current priority-table slot
- `vc_empty` in 4 — per-VC FIFO empty flag, bit n = VCn; FIFOs are first-word-fall-through
- `vc0_data`..`vc3_data` in DATA_W each — FIFO head words
- `dest_afull` in 1 — downstream almost-full
- `pop` out 4 — one-hot FIFO pop, combinational
- `sched_adv` out 1 — advance priority table one slot, combinational; wired to the table interface's enable
- `data_out` out DATA_W — registered granted word
- `valid_out` out 1 — registered, qualifies `data_out`
- `grant_vc` out 2 — registered, VC that produced `data_out`
- `fallback_cnt` out CNT_W — grants made by round-robin fallback
- `stall_cnt` out CNT_W — cycles spent in HOLD

## Operation
- States are IDLE, ACTIVE and HOLD. Reset state is IDLE.
- IDLE -> ACTIVE on `enb`=1.
- ACTIVE -> HOLD on `dest_afull`=1.
- HOLD -> ACTIVE on `dest_afull`=0.
- From any state, `enb`=0 -> IDLE. This takes priority over all other transitions.
- Grant window `gw` = (state==ACTIVE) & `enb` & !`dest_afull`. Outside `gw`: `pop`=0 and `sched_adv`=0.
- Inside `gw`, the rules apply in this order:
  - Primary: if !`vc_empty[sched_vc]`, pop `sched_vc` and assert `sched_adv`=1. `rr_ptr` is unchanged.
  - Fallback: if `sched_vc` is empty, search VCs in order `rr_ptr`+1, +2, +3, +4 (mod 4), skipping `sched_vc`. Take the first non-empty VC: pop it, assert `sched_adv`=1, set `rr_ptr` to the granted VC, and increment `fallback_cnt`. The slot counts as consumed.
  - All empty: `pop`=0 and `sched_adv`=0. The table slot is held and no counter changes.
- `pop` is always one-hot or zero. `sched_adv` is high exactly when `pop` != 0.
- `stall_cnt` increments on every cycle the state is HOLD and `enb`=1.
- Both counters saturate at 2^CNT_W−1; they never wrap. They clear only on reset.
- Reset values: `data_out`=0, `valid_out`=0, `grant_vc`=0, `rr_ptr`=3 (first fallback search starts at VC0), counters 0, state IDLE. `pop`=0 and `sched_adv`=0 while in reset.
- Reset asserted mid-operation: all registers return to reset values immediately. A pop already seen by a FIFO edge is not replayed.

## Timing
- `pop` and `sched_adv` are combinational from state, `enb`, `dest_afull`, `sched_vc`, `vc_empty` and `rr_ptr`. They are valid in the same cycle as the decision.
- Data latency is 1 cycle. On the edge ending a pop cycle: `data_out` <= head word of the granted VC, `grant_vc` <= granted VC, `valid_out` <= 1. On any cycle without a pop, `valid_out` <= 0 and `data_out`/`grant_vc` hold.
- `sched_vc` must reflect the new slot on the cycle after `sched_adv`. Because the table interface registers its output, the scheduler sees each new slot one cycle after advancing and must not assume a combinational update.
- `dest_afull` rising: no pop in that same cycle, and HOLD is entered on the next edge. Downstream must absorb the one `valid_out` already in flight.
- After `enb` rises from IDLE, the first possible pop is 1 cycle later.

## Test plan
- Primary grant: all VCs non-empty, slot sequence 3,2,3,0. Required: `pop`=1000,0100,1000,0001 on consecutive cycles; `grant_vc`=3,2,3,0 one cycle later; `fallback_cnt`=0.
- Fallback: `sched_vc`=2, `vc_empty`=0100, `rr_ptr`=3. Required: `pop`=0001, `sched_adv`=1, `fallback_cnt`=1. Next cycle with the same condition: `pop`=0010.
- All empty: `vc_empty`=1111 for 5 cycles, then VC1 non-empty with `sched_vc`=1. Required: `pop`=0 and `sched_adv`=0 for 5 cycles, then `pop`=0010 and `sched_adv`=1.
- Back-pressure: `dest_afull` high for 3 cycles mid-stream. Required: no pop while it is high; HOLD entered the next edge; `stall_cnt`=3 with `enb`=1. First pop resumes the cycle `dest_afull` is low in ACTIVE.
- Saturation: hold HOLD for 300 cycles. Required: `stall_cnt`=255, with no wrap.
- Reset mid-stream: drop `rst` low while `valid_out`=1. Required: immediately `valid_out`=0, `data_out`=0, counters 0, `pop`=0. After release with `enb`=1, the first pop comes one cycle after leaving IDLE.

Source files
------------

// File: rtl/vc_sched_arbiter_if.sv
// vc_sched_arbiter_if
//   Bundles the scheduler's FIFO-side, table-side and link-side signals.
//   slave  : the scheduler (consumes FIFO/table state, produces pop/adv/data)
//   master : the environment that drives the scheduler
// Signals:
//   enb          block enable
//   sched_vc     VC chosen by the current priority-table slot
//   vc_empty     per-VC FIFO empty flags (bit n = VCn)
//   vc0..3_data  FIFO head words (first-word-fall-through)
//   dest_afull   downstream almost-full
//   pop          one-hot FIFO pop (combinational)
//   sched_adv    priority-table advance (combinational)
//   data_out     registered granted word, qualified by valid_out
//   grant_vc     registered VC that produced data_out
//   fallback_cnt saturating count of round-robin fallback grants
//   stall_cnt    saturating count of enabled HOLD cycles
interface vc_sched_arbiter_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
);
    logic              enb;
    logic [1:0]        sched_vc;
    logic [3:0]        vc_empty;
    logic [DATA_W-1:0] vc0_data;
    logic [DATA_W-1:0] vc1_data;
    logic [DATA_W-1:0] vc2_data;
    logic [DATA_W-1:0] vc3_data;
    logic              dest_afull;
    logic [3:0]        pop;
    logic              sched_adv;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [1:0]        grant_vc;
    logic [CNT_W-1:0]  fallback_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    modport slave (
        input  enb, sched_vc, vc_empty, vc0_data, vc1_data, vc2_data, vc3_data, dest_afull,
        output pop, sched_adv, data_out, valid_out, grant_vc, fallback_cnt, stall_cnt
    );

    modport master (
        output enb, sched_vc, vc_empty, vc0_data, vc1_data, vc2_data, vc3_data, dest_afull,
        input  pop, sched_adv, data_out, valid_out, grant_vc, fallback_cnt, stall_cnt
    );
endinterface

// File: rtl/vc_sched_arbiter.sv
// vc_sched_arbiter
//   Virtual-channel scheduler between four VC FIFOs and the shared output
//   link. Each grant cycle it pops the VC named by the priority-table slot;
//   if that VC is empty it falls back to round-robin over the other VCs.
//   Pop and table-advance are combinational; the granted word is registered.
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous, active-low reset
//   bus  vc_sched_arbiter_if.slave (see interface header for signal list)
module vc_sched_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    vc_sched_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state, state_nxt;
    logic [1:0]        rr_ptr;
    logic              gw;
    logic [3:0]        pop_c;
    logic [1:0]        grant_idx;
    logic              fb_hit;
    logic [DATA_W-1:0] head;

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic [1:0]        grant_q;
    logic [CNT_W-1:0]  fallback_q;
    logic [CNT_W-1:0]  stall_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; a low enable overrides every other transition
    always_comb begin
        state_nxt = state;
        if (!bus.enb) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ACTIVE;
                ACTIVE:  state_nxt = bus.dest_afull ? HOLD : ACTIVE;
                HOLD:    state_nxt = bus.dest_afull ? HOLD : ACTIVE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Grant decision: primary slot first, else round-robin starting after
    // rr_ptr and skipping the (empty) slot VC. The fourth candidate is
    // rr_ptr itself, so every other VC gets a chance.
    // ------------------------------------------------------------------
    always_comb begin
        logic [1:0] cand;
        logic       found;
        gw        = (state == ACTIVE) && bus.enb && !bus.dest_afull;
        pop_c     = '0;
        grant_idx = bus.sched_vc;
        fb_hit    = 1'b0;
        cand      = '0;
        found     = 1'b0;
        if (gw) begin
            if (!bus.vc_empty[bus.sched_vc]) begin
                pop_c[bus.sched_vc] = 1'b1;
            end else begin
                for (int unsigned k = 1; k <= 4; k++) begin
                    cand = rr_ptr + k[1:0];
                    if (!found && (cand != bus.sched_vc) && !bus.vc_empty[cand]) begin
                        found     = 1'b1;
                        grant_idx = cand;
                    end
                end
                if (found) begin
                    pop_c[grant_idx] = 1'b1;
                    fb_hit           = 1'b1;
                end
            end
        end
    end

    always_comb begin
        head = '0;
        case (grant_idx)
            2'd0:    head = bus.vc0_data;
            2'd1:    head = bus.vc1_data;
            2'd2:    head = bus.vc2_data;
            default: head = bus.vc3_data;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register: one-cycle data latency, data/grant hold when idle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
        end else if (pop_c != '0) begin
            data_q  <= head;
            valid_q <= 1'b1;
            grant_q <= grant_idx;
        end else begin
            valid_q <= 1'b0;
        end
    end

    // Round-robin pointer moves only on fallback grants; reset value 3 makes
    // the first fallback search begin at VC0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= 2'd3;
        end else if (fb_hit) begin
            rr_ptr <= grant_idx;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fallback_q <= '0;
            stall_q    <= '0;
        end else begin
            if (fb_hit && (fallback_q != CNT_MAX)) begin
                fallback_q <= fallback_q + CNT_W'(1);
            end
            if ((state == HOLD) && bus.enb && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign bus.pop          = pop_c;
    assign bus.sched_adv    = |pop_c;
    assign bus.data_out     = data_q;
    assign bus.valid_out    = valid_q;
    assign bus.grant_vc     = grant_q;
    assign bus.fallback_cnt = fallback_q;
    assign bus.stall_cnt    = stall_q;

endmodule

// File: tb/tb_vc_sched_arbiter.sv
// tb_vc_sched_arbiter
//   Directed bench for vc_sched_arbiter. Inputs change just after the falling
//   edge; combinational outputs are checked 2 time units later, registered
//   outputs right at the following falling edge.
module tb_vc_sched_arbiter;

    logic clk;
    logic rst;

    int n_assert = 0;
    int n_fail   = 0;

    vc_sched_arbiter_if #(.DATA_W(8), .CNT_W(8)) bus ();

    vc_sched_arbiter #(.DATA_W(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [1:0] slots [4];
    logic [7:0] heads [4];

    initial begin
        slots = '{2'd3, 2'd2, 2'd3, 2'd0};
        heads = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

        rst            = 1'b0;
        bus.enb        = 1'b0;
        bus.sched_vc   = 2'd0;
        bus.vc_empty   = 4'hF;
        bus.dest_afull = 1'b0;
        bus.vc0_data   = 8'hA0;
        bus.vc1_data   = 8'hB1;
        bus.vc2_data   = 8'hC2;
        bus.vc3_data   = 8'hD3;
        #2;
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_grant", bus.grant_vc, 0);
        chk("rst_fb", bus.fallback_cnt, 0);
        chk("rst_stall", bus.stall_cnt, 0);
        chk("rst_pop", bus.pop, 0);
        chk("rst_adv", bus.sched_adv, 0);

        @(negedge clk);
        rst = 1'b1;

        // Enable from IDLE: no pop in the IDLE cycle
        @(negedge clk);
        bus.enb      = 1'b1;
        bus.vc_empty = 4'h0;
        bus.sched_vc = 2'd3;
        #2;
        chk("idle_pop", bus.pop, 0);
        chk("idle_adv", bus.sched_adv, 0);

        // Primary grants, slot sequence 3,2,3,0
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("prim_grant", bus.grant_vc, 32'(slots[i-1]));
                chk("prim_data", bus.data_out, 32'(heads[slots[i-1]]));
                chk("prim_valid", bus.valid_out, 1);
            end
            bus.sched_vc = slots[i];
            #2;
            chk("prim_pop", bus.pop, 32'(4'b0001 << slots[i]));
            chk("prim_adv", bus.sched_adv, 1);
        end
        @(negedge clk);
        chk("prim_grant_last", bus.grant_vc, 0);
        chk("prim_data_last", bus.data_out, 32'h0A0);
        chk("prim_fb", bus.fallback_cnt, 0);

        // Fallback: slot VC2 empty, rr_ptr=3 -> VC0, then VC1
        bus.vc_empty = 4'b0100;
        bus.sched_vc = 2'd2;
        #2;
        chk("fb1_pop", bus.pop, 32'b0001);
        chk("fb1_adv", bus.sched_adv, 1);
        @(negedge clk);
        chk("fb1_cnt", bus.fallback_cnt, 1);
        chk("fb1_grant", bus.grant_vc, 0);
        #2;
        chk("fb2_pop", bus.pop, 32'b0010);
        chk("fb2_adv", bus.sched_adv, 1);
        @(negedge clk);
        chk("fb2_cnt", bus.fallback_cnt, 2);
        chk("fb2_grant", bus.grant_vc, 1);
        chk("fb2_data", bus.data_out, 32'h0B1);

        // All empty for 5 cycles, then VC1 non-empty as slot VC
        bus.vc_empty = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("empty_pop", bus.pop, 0);
            chk("empty_adv", bus.sched_adv, 0);
            @(negedge clk);
            chk("empty_valid", bus.valid_out, 0);
            chk("empty_fb", bus.fallback_cnt, 2);
        end
        bus.vc_empty = 4'b1101;
        bus.sched_vc = 2'd1;
        #2;
        chk("refill_pop", bus.pop, 32'b0010);
        chk("refill_adv", bus.sched_adv, 1);
        @(negedge clk);
        chk("refill_grant", bus.grant_vc, 1);
        chk("refill_valid", bus.valid_out, 1);
        chk("refill_fb", bus.fallback_cnt, 2);

        // Back-pressure: dest_afull high for 3 cycles
        bus.vc_empty   = 4'h0;
        bus.sched_vc   = 2'd0;
        bus.dest_afull = 1'b1;
        #2;
        chk("bp_a_pop", bus.pop, 0);
        @(negedge clk);
        chk("bp_b_valid", bus.valid_out, 0);
        chk("bp_b_stall", bus.stall_cnt, 0);
        #2;
        chk("bp_b_pop", bus.pop, 0);
        @(negedge clk);
        chk("bp_c_stall", bus.stall_cnt, 1);
        #2;
        chk("bp_c_pop", bus.pop, 0);
        @(negedge clk);
        chk("bp_d_stall", bus.stall_cnt, 2);
        bus.dest_afull = 1'b0;
        #2;
        chk("bp_d_pop", bus.pop, 0);
        @(negedge clk);
        chk("bp_e_stall", bus.stall_cnt, 3);
        #2;
        chk("bp_e_pop", bus.pop, 32'b0001);
        @(negedge clk);
        chk("bp_e_valid", bus.valid_out, 1);
        chk("bp_e_grant", bus.grant_vc, 0);

        // Saturation: long HOLD
        bus.dest_afull = 1'b1;
        #2;
        chk("sat_pop", bus.pop, 0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 100) chk("sat_mid", bus.stall_cnt, 103);
        end
        chk("sat_stall", bus.stall_cnt, 255);
        chk("sat_hold_pop", bus.pop, 0);

        // Reset mid-stream while valid_out is high
        bus.dest_afull = 1'b0;
        @(negedge clk);
        #2;
        chk("pre_rst_pop", bus.pop, 32'b0001);
        @(negedge clk);
        chk("pre_rst_valid", bus.valid_out, 1);
        rst = 1'b0;
        #1;
        chk("mrst_valid", bus.valid_out, 0);
        chk("mrst_data", bus.data_out, 0);
        chk("mrst_grant", bus.grant_vc, 0);
        chk("mrst_fb", bus.fallback_cnt, 0);
        chk("mrst_stall", bus.stall_cnt, 0);
        chk("mrst_pop", bus.pop, 0);
        chk("mrst_adv", bus.sched_adv, 0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("post_rst_idle_pop", bus.pop, 0);
        @(negedge clk);
        bus.vc_empty = 4'b0100;
        bus.sched_vc = 2'd2;
        #2;
        chk("post_rst_pop", bus.pop, 32'b0001);
        chk("post_rst_adv", bus.sched_adv, 1);
        @(negedge clk);
        chk("post_rst_grant", bus.grant_vc, 0);
        chk("post_rst_valid", bus.valid_out, 1);
        chk("post_rst_fb", bus.fallback_cnt, 1);

        // Enable low forces IDLE and blocks grants immediately
        bus.enb      = 1'b0;
        bus.vc_empty = 4'h0;
        #2;
        chk("enb_low_pop", bus.pop, 0);
        chk("enb_low_adv", bus.sched_adv, 0);
        @(negedge clk);
        chk("enb_low_valid", bus.valid_out, 0);
        bus.enb = 1'b1;
        #2;
        chk("enb_idle_pop", bus.pop, 0);
        @(negedge clk);
        #2;
        chk("enb_resume_pop", bus.pop, 32'b0100);
        chk("enb_resume_adv", bus.sched_adv, 1);
        @(negedge clk);
        chk("enb_resume_data", bus.data_out, 32'h0C2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
